nibble_serial_add_ctrl: RTL

Sequencer that performs a wide (4*NIBBLES-bit) addition by time-sharing one 4-bit ripple adder, one nibble per clock, LSB nibble first.
- Carry is registered between nibbles; operands are captured on a start handshake; the result is held until the next operation.
- Sits between the register file / test top and the shared four_bit_adder instance, which it instantiates once internally.

---
 rtl/nibble_serial_add_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// | nibble_serial_add_ctrl : wide adder built from one shared 4-bit adder,   |
// |   one nibble per clock, LSB first. Optional NIBBLE_SERIAL_SUB_EN adds sub|
// | Revision: 1.0                                                            |
// ---------------------------------------------------------------------------
`default_nettype none

module four_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);
  logic [4:0] w_c;

  assign w_c[0] = c_in;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign c_out = w_c[4];
endmodule

module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   c_in,
`ifdef NIBBLE_SERIAL_SUB_EN
  input  logic                   sub,
`endif
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   c_out,
  output logic                   overflow
);
  localparam int C_WIDTH = 4 * NIBBLES;
  localparam int C_CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [C_WIDTH-1:0]   r_a_sr;
  logic [C_WIDTH-1:0]   r_b_sr;
  logic [C_WIDTH-1:0]   r_res;
  logic [C_CNT_W-1:0]   r_cnt;
  logic                 r_carry;
  logic                 r_sub;
  logic                 r_a_msb;
  logic                 r_b_msb;
  logic                 w_sub_in;
  logic [3:0]           w_b_nib;
  logic [3:0]           w_nsum;
  logic                 w_ncarry;

`ifdef NIBBLE_SERIAL_SUB_EN
  assign w_sub_in = sub;
`else
  assign w_sub_in = 1'b0;
`endif

  // Subtraction is a + ~b + 1: invert each B nibble on its way into the adder.
  assign w_b_nib = r_b_sr[3:0] ^ {4{r_sub}};

  four_bit_adder u_adder (
    .a     (r_a_sr[3:0]),
    .b     (w_b_nib),
    .c_in  (r_carry),
    .sum   (w_nsum),
    .c_out (w_ncarry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    ready  = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) w_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (r_cnt == C_LAST) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_sub    <= 1'b0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_sub   <= w_sub_in;
            r_carry <= c_in | w_sub_in;
            r_cnt   <= '0;
            // Sign bits are kept aside because the shift regs drain during RUN.
            r_a_msb <= a[C_WIDTH-1];
            r_b_msb <= b[C_WIDTH-1] ^ w_sub_in;
          end
        end
        S_RUN: begin
          r_res   <= {w_nsum, r_res[C_WIDTH-1:4]};
          r_carry <= w_ncarry;
          r_a_sr  <= {4'b0000, r_a_sr[C_WIDTH-1:4]};
          r_b_sr  <= {4'b0000, r_b_sr[C_WIDTH-1:4]};
          r_cnt   <= r_cnt + C_CNT_W'(1);
        end
        S_DONE: begin
          sum      <= r_res;
          c_out    <= r_carry;
          overflow <= (r_a_msb == r_b_msb) && (r_res[C_WIDTH-1] != r_a_msb);
        end
        default: ;
      endcase
    end
  end
endmodule

`default_nettype wire
